// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolution path: opcodes,
// prediction-queue entry layout and resolver FSM states.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } q_entry_t;

  localparam int ENTRY_W = $bits(q_entry_t);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction/resolution bus between the ID/EX stages and the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int HIST_BITS = 8
);
  logic                 pred_valid;
  logic [31:0]          pred_pc;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic                 res_valid;
  logic [31:0]          res_pc;
  logic                 res_taken;
  logic [31:0]          res_target;
  logic                 q_full;
  logic                 flush;
  logic [31:0]          redirect_pc;
  logic                 upd_valid;
  logic [HIST_BITS-1:0] upd_addr;
  logic                 upd_taken;
  logic                 proto_err;
  logic [31:0]          branch_cnt;
  logic [31:0]          mispred_cnt;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_pc, res_taken, res_target,
    input  q_full, flush, redirect_pc, upd_valid, upd_addr, upd_taken,
    input  proto_err, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_pc, res_taken, res_target,
    output q_full, flush, redirect_pc, upd_valid, upd_addr, upd_taken,
    output proto_err, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit_pred_fifo.sv
// Circular FIFO of in-flight predictions; clear drops every entry at once.
module pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches EX branch outcomes against queued ID predictions, drives flush/redirect,
// predictor updates and performance counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int RECOVER_CYC = 2,
  parameter int HIST_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);
  localparam int CW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        rcnt_q, rcnt_d;
  logic                 flush_q, flush_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [HIST_BITS-1:0] upd_addr_q, upd_addr_d;
  logic                 upd_taken_q, upd_taken_d;
  logic                 proto_err_q, proto_err_d;
  logic [31:0]          branch_cnt_q, branch_cnt_d;
  logic [31:0]          mispred_cnt_q, mispred_cnt_d;

  logic                 accept;
  logic                 res_acc;
  logic                 mispredict;
  logic                 push;
  logic                 q_empty;
  logic                 q_full;
  logic [ENTRY_W-1:0]   head_raw;
  q_entry_t             head;
  q_entry_t             new_entry;

  assign head      = q_entry_t'(head_raw);
  assign new_entry = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

  assign accept  = (state_q == ST_RUN);
  assign res_acc = accept && bus.res_valid && !q_empty;

  // A head PC that does not match the resolving PC means the queue lost sync,
  // so recovery is forced the same way as a genuine mispredict.
  assign mispredict = res_acc &&
                      ((head.taken != bus.res_taken) ||
                       (bus.res_taken && (head.target != bus.res_target)) ||
                       (head.pc != bus.res_pc));

  assign push = accept && bus.pred_valid && !mispredict;

  pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (mispredict),
    .push  (push),
    .pop   (res_acc),
    .wdata (new_entry),
    .rdata (head_raw),
    .empty (q_empty),
    .full  (q_full)
  );

  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    flush_d       = mispredict;
    redirect_pc_d = redirect_pc_q;
    upd_valid_d   = res_acc;
    upd_addr_d    = upd_addr_q;
    upd_taken_d   = upd_taken_q;
    proto_err_d   = proto_err_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (res_acc) begin
      upd_addr_d   = bus.res_pc[HIST_BITS-1:0];
      upd_taken_d  = bus.res_taken;
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (head.pc != bus.res_pc) proto_err_d = 1'b1;
    end
    if (accept && bus.res_valid && q_empty) proto_err_d = 1'b1;
    if (push && q_full && !res_acc) proto_err_d = 1'b1;

    if (mispredict) begin
      redirect_pc_d = bus.res_taken ? bus.res_target : (bus.res_pc + 32'd4);
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_RECOVER;
          rcnt_d  = CW'(RECOVER_CYC - 1);
        end
      end
      ST_RECOVER: begin
        if (rcnt_q == '0) state_d = ST_RUN;
        else              rcnt_d  = rcnt_q - 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      rcnt_q        <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_taken_q   <= 1'b0;
      proto_err_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      upd_valid_q   <= upd_valid_d;
      upd_addr_q    <= upd_addr_d;
      upd_taken_q   <= upd_taken_d;
      proto_err_q   <= proto_err_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.q_full      = q_full;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_addr    = upd_addr_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.proto_err   = proto_err_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  branch_resolve_unit_if #(.HIST_BITS(8)) bus ();

  branch_resolve_unit #(
    .DEPTH       (4),
    .RECOVER_CYC (2),
    .HIST_BITS   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: inputs set at negedge, outputs sampled 1ns after the edge.
  task automatic applyStimulus(input logic pv, input logic [31:0] ppc, input logic pt,
                               input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
                               input logic rt, input logic [31:0] rtg);
    @(negedge clk);
    bus.pred_valid  = pv;
    bus.pred_pc     = ppc;
    bus.pred_taken  = pt;
    bus.pred_target = ptg;
    bus.res_valid   = rv;
    bus.res_pc      = rpc;
    bus.res_taken   = rt;
    bus.res_target  = rtg;
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_taken = 0; bus.pred_target = 0;
    bus.res_valid = 0;  bus.res_pc = 0;  bus.res_taken = 0;  bus.res_target = 0;
    repeat (2) @(posedge clk);
    doReset();

    checkOutput("rst_flush",   32'(bus.flush), 0);
    checkOutput("rst_upd",     32'(bus.upd_valid), 0);
    checkOutput("rst_redir",   bus.redirect_pc, 0);
    checkOutput("rst_perr",    32'(bus.proto_err), 0);
    checkOutput("rst_bcnt",    bus.branch_cnt, 0);
    checkOutput("rst_mcnt",    bus.mispred_cnt, 0);
    checkOutput("rst_full",    32'(bus.q_full), 0);

    // Correct not-taken
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 0, 0);
    checkOutput("nt_upd",      32'(bus.upd_valid), 1);
    checkOutput("nt_addr",     32'(bus.upd_addr), 32'h00);
    checkOutput("nt_taken",    32'(bus.upd_taken), 0);
    checkOutput("nt_flush",    32'(bus.flush), 0);
    checkOutput("nt_bcnt",     bus.branch_cnt, 1);
    checkOutput("nt_mcnt",     bus.mispred_cnt, 0);
    idle(1);
    checkOutput("nt_upd_pulse", 32'(bus.upd_valid), 0);

    // Taken predicted, not taken actual; younger 0x208 is wrong-path
    applyStimulus(1, 32'h200, 1, 32'h240, 0, 0, 0, 0);
    applyStimulus(1, 32'h208, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0);
    checkOutput("t2n_flush",   32'(bus.flush), 1);
    checkOutput("t2n_redir",   bus.redirect_pc, 32'h204);
    checkOutput("t2n_mcnt",    bus.mispred_cnt, 1);
    checkOutput("t2n_bcnt",    bus.branch_cnt, 2);
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
    checkOutput("t2n_flush_pulse", 32'(bus.flush), 0);
    checkOutput("t2n_redir_hold",  bus.redirect_pc, 32'h204);
    applyStimulus(1, 32'h504, 0, 0, 1, 32'h208, 0, 0);
    checkOutput("rec_res_ignored", 32'(bus.upd_valid), 0);

    // Not-taken predicted, taken actual; stale entries would cause a PC mismatch
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h300, 1, 32'h280);
    checkOutput("n2t_flush",   32'(bus.flush), 1);
    checkOutput("n2t_redir",   bus.redirect_pc, 32'h280);
    checkOutput("n2t_mcnt",    bus.mispred_cnt, 2);
    checkOutput("n2t_perr",    32'(bus.proto_err), 0);
    idle(2);

    // Target mispredict (jalr)
    applyStimulus(1, 32'h300, 1, 32'h400, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h300, 1, 32'h480);
    checkOutput("tgt_flush",   32'(bus.flush), 1);
    checkOutput("tgt_redir",   bus.redirect_pc, 32'h480);
    checkOutput("tgt_taken",   32'(bus.upd_taken), 1);
    checkOutput("tgt_mcnt",    bus.mispred_cnt, 3);
    checkOutput("tgt_bcnt",    bus.branch_cnt, 4);
    checkOutput("tgt_perr",    32'(bus.proto_err), 0);
    idle(2);

    // Fill, simultaneous push/pop while full, dropped push
    for (int i = 0; i < 4; i++) begin
      checkOutput("fill_notfull", 32'(bus.q_full), 0);
      applyStimulus(1, 32'h10 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
    end
    checkOutput("fill_full",   32'(bus.q_full), 1);
    applyStimulus(1, 32'h20, 0, 0, 1, 32'h10, 0, 0);
    checkOutput("pp_full",     32'(bus.q_full), 1);
    checkOutput("pp_upd",      32'(bus.upd_valid), 1);
    checkOutput("pp_flush",    32'(bus.flush), 0);
    checkOutput("pp_bcnt",     bus.branch_cnt, 5);
    checkOutput("pp_perr",     32'(bus.proto_err), 0);
    applyStimulus(1, 32'h24, 0, 0, 0, 0, 0, 0);
    checkOutput("drop_perr",   32'(bus.proto_err), 1);
    checkOutput("drop_full",   32'(bus.q_full), 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h14, 0, 0);
    checkOutput("head_adv_flush", 32'(bus.flush), 0);
    checkOutput("head_adv_full",  32'(bus.q_full), 0);
    checkOutput("head_adv_bcnt",  bus.branch_cnt, 6);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 32'h18 + 32'(4 * i), 0, 0);
    checkOutput("drain_flush", 32'(bus.flush), 0);
    checkOutput("drain_bcnt",  bus.branch_cnt, 9);

    // Resolve with empty queue
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 32'h50, 0, 0);
    checkOutput("empty_perr",  32'(bus.proto_err), 1);
    checkOutput("empty_upd",   32'(bus.upd_valid), 0);
    checkOutput("empty_bcnt",  bus.branch_cnt, 0);

    // Reset during recovery
    doReset();
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h600, 1, 32'h700);
    checkOutput("rr_flush",    32'(bus.flush), 1);
    doReset();
    checkOutput("rr_flush0",   32'(bus.flush), 0);
    checkOutput("rr_redir0",   bus.redirect_pc, 0);
    checkOutput("rr_mcnt0",    bus.mispred_cnt, 0);
    checkOutput("rr_bcnt0",    bus.branch_cnt, 0);
    applyStimulus(1, 32'h610, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h610, 0, 0);
    checkOutput("rr_upd",      32'(bus.upd_valid), 1);
    checkOutput("rr_perr",     32'(bus.proto_err), 0);

    // Counter wrap and redirect wrap
    @(negedge clk);
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    applyStimulus(1, 32'hFFFF_FFFC, 1, 32'h1000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    checkOutput("wrap_bcnt",   bus.branch_cnt, 0);
    checkOutput("wrap_flush",  32'(bus.flush), 1);
    checkOutput("wrap_redir",  bus.redirect_pc, 32'h0000_0000);
    checkOutput("wrap_addr",   32'(bus.upd_addr), 32'hFC);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution end of the branch-prediction path.
- Records each prediction the ID-stage controller makes, in program order, in a small queue.
- Checks each prediction against the outcome computed in EX.
- Drives the pipeline flush and fetch redirect, and the gshare update strobe (pc[7:0], taken).
- Keeps 32-bit branch and mispredict counters for performance measurement.

Parameters:
- DEPTH, 4: prediction-queue entries (power of 2, minimum 2).
- RECOVER_CYC, 2: cycles after a flush during which pushes and resolves are ignored while wrong-path instructions drain.
- HIST_BITS, 8: width of the update address sent to the predictor.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pred_valid  in  1  ID has predicted a branch, jal or jalr this cycle
- pred_pc  in  32  PC of the predicted instruction
- pred_taken  in  1  predicted direction
- pred_target  in  32  predicted next PC when taken
- res_valid  in  1  EX resolves the oldest in-flight control instruction
- res_pc  in  32  PC of the resolving instruction
- res_taken  in  1  actual direction
- res_target  in  32  actual target when taken
- q_full  out  1  queue full; ID must stall further control-flow instructions
- flush  out  1  one-cycle squash of IF/ID/EX
- redirect_pc  out  32  correct next PC, valid with flush
- upd_valid  out  1  gshare update strobe
- upd_addr  out  HIST_BITS  res_pc[HIST_BITS-1:0]
- upd_taken  out  1  actual direction for the update
- proto_err  out  1  sticky: resolve with empty queue, or head PC mismatch
- branch_cnt  out  32  resolved control instructions, wraps
- mispred_cnt  out  32  mispredictions, wraps

Behaviour:
- Reset (rst=1 at a clk edge):
  - Queue emptied; state RUN.
  - All outputs 0, including both counters, proto_err and redirect_pc.
  - Reset mid-recovery aborts the recovery.
- Queue: circular FIFO, DEPTH entries of {pc, taken, target}.
  - Pointers are log2(DEPTH)+1 bits.
  - q_full is combinational from the pointers.
  - Push and pop in the same cycle are legal, including when full; occupancy is unchanged.
  - A push while full with no pop is dropped and sets proto_err.
- FSM states: RUN and RECOVER.
  - In RUN, pushes and resolves are accepted.
  - RUN to RECOVER on a mispredict; the down-counter loads RECOVER_CYC-1.
  - In RECOVER, pred_valid and res_valid are ignored.
  - RECOVER to RUN when the counter reaches 0.
- Resolve in RUN with res_valid=1 and queue non-empty:
  - Pop the head entry.
  - mispredict = (head.taken != res_taken) | (res_taken & head.target != res_target).
  - If head.pc != res_pc: set proto_err and treat the resolve as a mispredict.
- Outputs are registered, one cycle after res_valid:
  - upd_valid=1, upd_addr=res_pc[HIST_BITS-1:0], upd_taken=res_taken for every accepted resolve.
  - branch_cnt increments by 1 for every accepted resolve.
  - On mispredict: flush=1, redirect_pc = res_taken ? res_target : res_pc+4 (32-bit, wraps), mispred_cnt increments by 1.
  - The whole queue is cleared, since every younger entry is wrong-path.
  - A pred_valid in the same cycle as the mispredicting resolve is dropped.
  - flush and upd_valid are single-cycle pulses. redirect_pc holds its last value.
- Resolve in RUN with the queue empty: no pop, no update, proto_err=1.
- Correct prediction: no flush, the state stays RUN, and a same-cycle push is accepted.
- jal: resolved like a branch with res_taken=1.

Decomposition:
- Shared package: opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111, the queue-entry struct/width constants, and the FSM state encodings.
- One sub-module, pred_fifo (parameterised DEPTH/width circular FIFO with a synchronous clear). Compare logic, FSM and counters stay in the top module.

Test Plan:
- Correct not-taken: push pc=0x100 taken=0, resolve pc=0x100 taken=0 -> next cycle upd_valid=1, upd_addr=0x00, upd_taken=0, flush=0, branch_cnt=1, mispred_cnt=0.
- Direction mispredict, taken-to-not-taken: push pc=0x200 taken=1 target=0x240, then pc=0x208; resolve 0x200 taken=0 -> flush=1, redirect_pc=0x204, mispred_cnt=1, queue empty.
  - Pushes on the next RECOVER_CYC=2 cycles are ignored.
- Direction mispredict, not-taken-to-taken: push pc=0x300 taken=0; resolve 0x300 taken=1 target=0x280 -> flush=1, redirect_pc=0x280.
- Target mispredict: jalr push pc=0x300 taken=1 target=0x400; resolve taken=1 target=0x480 -> flush=1, redirect_pc=0x480, upd_taken=1.
- Full and simultaneous: fill 4 entries -> q_full=1.
  - Push and correct-resolve in the same cycle -> occupancy stays 4, head advances.
  - Push alone while full -> dropped, proto_err=1.
- Errors and reset: res_valid with empty queue -> proto_err=1, no upd_valid.
  - rst=1 during RECOVER -> next cycle all outputs 0, state RUN, a push is accepted.
- Wrap: preload branch_cnt to 0xFFFFFFFF via 2^32 resolves (or force) -> one more resolve gives 0.
  - Mispredict at res_pc=0xFFFFFFFC, not taken -> redirect_pc=0x00000000.
